// File: rtl/mt_recovery_if.sv
// ROB-commit / map-table-restore bundle for mt_recovery.
// Carries mt_recovery_err only when MT_RECOVERY_CHECK_EN is defined.
interface mt_recovery_if #(
  parameter int COPY_WIDTH = 4,
  parameter int PR_BITS    = 7
);
  logic [1:0]                    rob_retire_num;
  logic [4:0]                    rob_retire_ar0;
  logic [4:0]                    rob_retire_ar1;
  logic [PR_BITS-1:0]            rob_retire_pr0;
  logic [PR_BITS-1:0]            rob_retire_pr1;
  logic                          rob_retire_valid0;
  logic                          rob_retire_valid1;
  logic                          rob_mispredict;
  logic                          mt_restore_en;
  logic [4:0]                    mt_restore_idx;
  logic [COPY_WIDTH*PR_BITS-1:0] mt_restore_pr;
  logic                          mt_stall_dispatch;
  logic                          mt_recovery_done;
`ifdef MT_RECOVERY_CHECK_EN
  logic                          mt_recovery_err;

  modport master (
    output rob_retire_num, rob_retire_ar0, rob_retire_ar1, rob_retire_pr0,
           rob_retire_pr1, rob_retire_valid0, rob_retire_valid1, rob_mispredict,
    input  mt_restore_en, mt_restore_idx, mt_restore_pr, mt_stall_dispatch,
           mt_recovery_done, mt_recovery_err
  );

  modport slave (
    input  rob_retire_num, rob_retire_ar0, rob_retire_ar1, rob_retire_pr0,
           rob_retire_pr1, rob_retire_valid0, rob_retire_valid1, rob_mispredict,
    output mt_restore_en, mt_restore_idx, mt_restore_pr, mt_stall_dispatch,
           mt_recovery_done, mt_recovery_err
  );
`else
  modport master (
    output rob_retire_num, rob_retire_ar0, rob_retire_ar1, rob_retire_pr0,
           rob_retire_pr1, rob_retire_valid0, rob_retire_valid1, rob_mispredict,
    input  mt_restore_en, mt_restore_idx, mt_restore_pr, mt_stall_dispatch,
           mt_recovery_done
  );

  modport slave (
    input  rob_retire_num, rob_retire_ar0, rob_retire_ar1, rob_retire_pr0,
           rob_retire_pr1, rob_retire_valid0, rob_retire_valid1, rob_mispredict,
    output mt_restore_en, mt_restore_idx, mt_restore_pr, mt_stall_dispatch,
           mt_recovery_done
  );
`endif
endinterface

// File: rtl/mt_recovery.sv
// Architectural map keeper that streams the retirement map back into the map table after a mispredict.
// Optional protocol checker (mt_recovery_err) enabled by defining MT_RECOVERY_CHECK_EN.
module mt_recovery #(
  parameter int COPY_WIDTH = 4,
  parameter int NUM_AR     = 32,
  parameter int PR_BITS    = 7
) (
  input  logic          clock,
  input  logic          reset,
  mt_recovery_if.slave  bus
);
  localparam int IDX_W      = 5;
  localparam int NUM_CHUNKS = NUM_AR / COPY_WIDTH;
  localparam int CNT_W      = $clog2(NUM_CHUNKS);
  localparam int LAST       = NUM_CHUNKS - 1;

  typedef enum logic {IDLE, COPY} state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [PR_BITS-1:0]            r_archMap [NUM_AR];
  logic                          r_restoreEn;
  logic [IDX_W-1:0]              r_restoreIdx;
  logic [COPY_WIDTH*PR_BITS-1:0] r_restorePr;
  logic                          r_done;

  logic [PR_BITS-1:0]            w_archNext [NUM_AR];
  logic [CNT_W-1:0]              w_nextCnt;
  logic [IDX_W-1:0]              w_baseIdx;
  logic [COPY_WIDTH*PR_BITS-1:0] w_chunkPr;

  // Slot 1 is written last so the younger commit wins on an AR collision.
  always_comb begin
    w_archNext = r_archMap;
    if (r_state == IDLE) begin
      if (bus.rob_retire_num != 2'd0 && bus.rob_retire_valid0)
        w_archNext[bus.rob_retire_ar0] = bus.rob_retire_pr0;
      if (bus.rob_retire_num == 2'd2 && bus.rob_retire_valid1)
        w_archNext[bus.rob_retire_ar1] = bus.rob_retire_pr1;
    end
  end

  // Chunks read the post-commit map so a branch committing in its own mispredict cycle is restored.
  always_comb begin
    w_nextCnt = (r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
    w_baseIdx = IDX_W'(w_nextCnt) * IDX_W'(COPY_WIDTH);
    w_chunkPr = '0;
    for (int k = 0; k < COPY_WIDTH; k++)
      w_chunkPr[k*PR_BITS +: PR_BITS] = w_archNext[w_baseIdx + IDX_W'(k)];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AR; i++)
        r_archMap[i] <= PR_BITS'(i);
    end else begin
      r_archMap <= w_archNext;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_restoreEn  <= 1'b0;
      r_restoreIdx <= '0;
      r_restorePr  <= '0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.rob_mispredict) begin
            r_state      <= COPY;
            r_cnt        <= '0;
            r_restoreEn  <= 1'b1;
            r_restoreIdx <= w_baseIdx;
            r_restorePr  <= w_chunkPr;
            r_done       <= 1'b0;
          end else begin
            r_restoreEn  <= 1'b0;
            r_restoreIdx <= '0;
            r_restorePr  <= '0;
            r_done       <= 1'b0;
          end
        end
        COPY: begin
          if (r_cnt == CNT_W'(LAST)) begin
            r_state      <= IDLE;
            r_restoreEn  <= 1'b0;
            r_restoreIdx <= '0;
            r_restorePr  <= '0;
            r_done       <= 1'b0;
          end else begin
            r_cnt        <= w_nextCnt;
            r_restoreEn  <= 1'b1;
            r_restoreIdx <= w_baseIdx;
            r_restorePr  <= w_chunkPr;
            r_done       <= (w_nextCnt == CNT_W'(LAST));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mt_restore_en     = r_restoreEn;
  assign bus.mt_restore_idx    = r_restoreIdx;
  assign bus.mt_restore_pr     = r_restorePr;
  assign bus.mt_recovery_done  = r_done;
  assign bus.mt_stall_dispatch = reset & (bus.rob_mispredict | (r_state == COPY));

`ifdef MT_RECOVERY_CHECK_EN
  logic r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_err <= 1'b0;
    else if (r_state == COPY && (bus.rob_retire_num != 2'd0 || bus.rob_mispredict))
      r_err <= 1'b1;
  end

  assign bus.mt_recovery_err = r_err;
`endif
endmodule

// File: doc/mt_recovery.md
# mt_recovery

Sequences map-table rollback after a branch mispredict or exception. The block keeps a retirement (architectural) map, 32 entries of 7-bit physical-register tags, updated from ROB commits. On a mispredict it streams that map back into the speculative map table, COPY_WIDTH entries per cycle, and holds dispatch stalled until the copy is complete. It sits between the ROB commit port and the map table's restore port.

## Interface
Parameters:
- COPY_WIDTH, default 4: map entries restored per cycle. Legal values are 1, 2, 4 and 8.
- NUM_AR, default 32: number of architectural registers. Fixed at 32.
- PR_BITS, default 7: width of a physical-register tag.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rob_retire_num  in  2  number of instructions committing this cycle (0, 1 or 2).
- rob_retire_ar0, rob_retire_ar1  in  5 each  destination architectural registers of commit slots 0 and 1.
- rob_retire_pr0, rob_retire_pr1  in  7 each  physical tags of commit slots 0 and 1.
- rob_retire_valid0, rob_retire_valid1  in  1 each  slot has a destination register; 0 means no map write for that slot.
- rob_mispredict  in  1  single-cycle request to start recovery.
- mt_restore_en  out  1  the restore bus is valid this cycle.
- mt_restore_idx  out  5  architectural index of lane 0; lane k restores entry idx+k.
- mt_restore_pr  out  COPY_WIDTH*7  restored tags; lane k occupies bits [7k+6:7k].
- mt_stall_dispatch  out  1  dispatch must be held this cycle.
- mt_recovery_done  out  1  single-cycle pulse marking the final restore cycle.

## Operation
- Architectural map reset value: entry i = i, the same identity mapping the map table uses at reset.
- Commit handling (IDLE state only):
  - Slot 0 is applied when rob_retire_num ≥ 1 and rob_retire_valid0 = 1.
  - Slot 1 is applied when rob_retire_num = 2 and rob_retire_valid1 = 1.
  - If both slots name the same AR, slot 1 (the younger) wins.
  - A commit in the same cycle as rob_mispredict is applied before the copy starts, because the branch commits itself.
- FSM states: IDLE, COPY.
  - IDLE → COPY when rob_mispredict = 1. The copy counter is cleared to 0.
  - In COPY the block drives mt_restore_en = 1, mt_restore_idx = cnt*COPY_WIDTH, and lanes = arch_map[idx+k]. The counter increments each cycle.
  - COPY → IDLE after the cycle with cnt = 32/COPY_WIDTH − 1. mt_recovery_done pulses in that cycle.
- mt_stall_dispatch = rob_mispredict OR (state == COPY).
- In COPY, commit inputs and rob_mispredict are ignored. The ROB is flushed during recovery and must present rob_retire_num = 0.
- Counter width is log2(32/COPY_WIDTH) bits. It never wraps within a recovery.
- Reset asserted mid-copy aborts the copy immediately:
  - state returns to IDLE;
  - the architectural map returns to identity;
  - every output goes to 0.

## Timing
- Reset values: mt_restore_en = 0, mt_restore_idx = 0, mt_restore_pr = 0, mt_stall_dispatch = 0 (the rob_mispredict term is also ignored while reset is low), mt_recovery_done = 0.
- rob_mispredict arrives at cycle T.
  - Stall is high from T through T+32/COPY_WIDTH.
  - Restore chunks are driven in cycles T+1 … T+32/COPY_WIDTH.
  - Done pulses at T+32/COPY_WIDTH.
  - IDLE is reached at T+32/COPY_WIDTH+1, when dispatch may resume.
- With the default COPY_WIDTH = 4, a recovery takes 8 copy cycles and 9 stall cycles in total.
- The commit-to-architectural-map write takes effect one cycle after it is presented.
- All restore outputs are registered. Only mt_stall_dispatch has a combinational path, from rob_mispredict.
- A back-to-back rob_mispredict at T+32/COPY_WIDTH+1 starts a new recovery with no idle gap.

## Configuration
- MT_RECOVERY_CHECK_EN defined:
  - Adds the output port mt_recovery_err (1 bit, sticky, reset 0).
  - It sets when, during COPY, rob_retire_num ≠ 0 or rob_mispredict = 1.
  - It is cleared only by reset.
- MT_RECOVERY_CHECK_EN undefined: the port and its logic are absent. Protocol violations are silently ignored exactly as described in Operation.

## Test plan
- Identity restore. Reset, then pulse rob_mispredict with no commits.
  - Expect 8 restore cycles with idx 0, 4, …, 28 and lanes equal to idx+k.
  - Expect done in the 8th restore cycle and stall high for 9 cycles.
- Commit then recover.
  - Commit ar 3→pr 40 and ar 9→pr 41 (num = 2).
  - Next cycle, pulse mispredict.
  - Expect chunk idx 0 lane 3 = 40 and chunk idx 8 lane 1 = 41.
- Same-AR dual commit. Commit slot 0 ar 5→pr 50 and slot 1 ar 5→pr 60, then mispredict. Expect entry 5 restored as 60.
- Commit in the mispredict cycle.
  - Commit ar 31→pr 99 in the same cycle as rob_mispredict.
  - Expect the last chunk lane 3 = 99, and stall high in that same cycle.
- Reset mid-copy.
  - Assert reset at the 4th restore cycle.
  - Expect all outputs 0 immediately.
  - After release, a new mispredict restores the identity map.
- Violation check (MT_RECOVERY_CHECK_EN defined).
  - Drive rob_retire_num = 1 during COPY.
  - Expect the architectural map unchanged and mt_recovery_err = 1 until reset.
